chaos_stream_cipher: RTL and testbench

//  Streaming chaos-based image cipher: successor to the frame-array encryptor, parametrised in pixel width,

---
 rtl/chaos_stream_cipher.sv | 190 +++++++++++++++++++
 tb/tb_chaos_stream_cipher.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chaos_stream_cipher.sv
// chaos_stream_cipher: streaming chaos-based pixel cipher.
// Each channel has its own fixed-point logistic-map lane that produces a keystream byte.
// A cipher-feedback substitution combines that byte with the pixel sample.
// One pixel (all channels) is processed per accepted beat, with a single registered output stage.
// Optional build macro: CHAOS_DECRYPT_EN adds a per-beat `mode` input (1 = decrypt).
//
// state      | meaning
// ST_UNKEYED | no key latched since reset, input side held off
// ST_KEYED   | key latched, lanes seeded, pixels may stream
`timescale 1ns/1ps
module chaos_stream_cipher #(
  parameter int PIX_W = 8,
  parameter int CH    = 3,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int X_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef CHAOS_DECRYPT_EN
  input  logic                mode,
`endif
  input  logic                key_load,
  input  logic [X_W-1:0]      key_x0,
  input  logic [X_W-1:0]      key_r,
  input  logic [PIX_W-1:0]    key_iv,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CH*PIX_W-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CH*PIX_W-1:0] m_data,
  output logic                m_last
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);

  typedef enum logic {ST_UNKEYED = 1'b0, ST_KEYED = 1'b1} state_t;

  state_t state, state_nxt;
  logic   keyed;
  logic   accept;
  logic   frame_end;
  logic   dec;

  logic [X_W-1:0]   key_x0_q;
  logic [X_W-1:0]   key_r_q;
  logic [PIX_W-1:0] key_iv_q;
  logic [CNT_W-1:0] pix_cnt;

  logic [X_W-1:0]   x_q      [CH];
  logic [PIX_W-1:0] prev_q   [CH];
  logic [X_W-1:0]   x_nxt    [CH];
  logic [PIX_W-1:0] prev_nxt [CH];
  logic [X_W-1:0]   seed_new [CH];
  logic [X_W-1:0]   seed_old [CH];
  logic [CH*PIX_W-1:0] result;

`ifdef CHAOS_DECRYPT_EN
  assign dec = mode;
`else
  assign dec = 1'b0;
`endif

  // Lane c starts from the seed rotated left by c so lanes diverge; zero is a fixed point, so it is bumped to 1.
  function automatic logic [X_W-1:0] lane_seed(input logic [X_W-1:0] v, input int amt);
    logic [X_W-1:0] s;
    s = (v << amt) | (v >> (X_W - amt));
    if (s == '0) s = X_W'(1);
    return s;
  endfunction

  // One logistic-map iteration: x' = r * x * (1 - x) in fixed point, never allowed to collapse to 0.
  function automatic logic [X_W-1:0] map_step(input logic [X_W-1:0] x, input logic [X_W-1:0] r);
    logic [X_W-1:0]   xi;
    logic [X_W-1:0]   q;
    logic [X_W-1:0]   nx;
    logic [2*X_W-1:0] sq;
    logic [2*X_W-1:0] rq;
    xi = ~x;
    sq = {{X_W{1'b0}}, x} * {{X_W{1'b0}}, xi};
    q  = X_W'(sq >> X_W);
    rq = {{X_W{1'b0}}, r} * {{X_W{1'b0}}, q};
    nx = X_W'(rq >> (X_W - 2));
    if (nx == '0) nx = X_W'(1);
    return nx;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_UNKEYED;
    else     state <= state_nxt;
  end

  // FSM next state: the first key load unlocks streaming; only reset relocks it
  always_comb begin
    state_nxt = state;
    if (key_load) state_nxt = ST_KEYED;
  end

  // FSM outputs: key_load takes priority over a same-cycle beat
  always_comb begin
    keyed   = (state == ST_KEYED);
    s_ready = keyed && !key_load && (!m_valid || m_ready);
  end

  assign accept    = s_valid && s_ready;
  assign frame_end = (pix_cnt == CNT_LAST);

  // Per-lane keystream, substitution, feedback and next map state
  always_comb begin
    logic [PIX_W-1:0] k;
    logic [PIX_W-1:0] p;
    logic [PIX_W-1:0] r;
    result = '0;
    k = '0;
    p = '0;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      x_nxt[c]    = map_step(x_q[c], key_r_q);
      seed_new[c] = lane_seed(key_x0, c % X_W);
      seed_old[c] = lane_seed(key_x0_q, c % X_W);
      k = x_q[c][X_W-1 -: PIX_W];
      p = s_data[c*PIX_W +: PIX_W];
      if (dec) begin
        r           = (p ^ prev_q[c]) - k;
        prev_nxt[c] = p;
      end else begin
        r           = (p + k) ^ prev_q[c];
        prev_nxt[c] = r;
      end
      result[c*PIX_W +: PIX_W] = r;
    end
  end

  // Key store, lane state and pixel counter; a key load or a frame end restarts every lane
  always_ff @(posedge clk) begin
    if (rst) begin
      key_x0_q <= '0;
      key_r_q  <= '0;
      key_iv_q <= '0;
      pix_cnt  <= '0;
      for (int c = 0; c < CH; c++) begin
        x_q[c]    <= '0;
        prev_q[c] <= '0;
      end
    end else if (key_load) begin
      key_x0_q <= key_x0;
      key_r_q  <= key_r;
      key_iv_q <= key_iv;
      pix_cnt  <= '0;
      for (int c = 0; c < CH; c++) begin
        x_q[c]    <= seed_new[c];
        prev_q[c] <= key_iv;
      end
    end else if (accept) begin
      if (frame_end) begin
        pix_cnt <= '0;
        for (int c = 0; c < CH; c++) begin
          x_q[c]    <= seed_old[c];
          prev_q[c] <= key_iv_q;
        end
      end else begin
        pix_cnt <= pix_cnt + CNT_W'(1);
        for (int c = 0; c < CH; c++) begin
          x_q[c]    <= x_nxt[c];
          prev_q[c] <= prev_nxt[c];
        end
      end
    end
  end

  // Output register: load on accept, clear valid only on a drain with nothing new
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= result;
      m_last  <= frame_end;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chaos_stream_cipher.sv
// Bench for chaos_stream_cipher: directed phases plus random traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_chaos_stream_cipher;
  localparam int PIX_W = 8;
  localparam int CH    = 3;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int X_W   = 16;
  localparam int NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_r;
  logic        key_load;
  logic [15:0] key_x0;
  logic [15:0] key_r;
  logic [7:0]  key_iv;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_last;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int   mx    [CH];
  int   mprev [CH];
  int   mcnt;
  bit   mkeyed;
  bit   mv;
  int   kx0, kr, kiv;
  logic [23:0] exp_data;
  logic        exp_last;

  logic [23:0] frame_px [NPIX];
  logic [23:0] ref_out  [NPIX];
  logic [23:0] plain    [64];
  logic [23:0] ciph     [64];

  chaos_stream_cipher #(
    .PIX_W(PIX_W), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef CHAOS_DECRYPT_EN
    .mode(mode_r),
`endif
    .key_load(key_load),
    .key_x0(key_x0),
    .key_r(key_r),
    .key_iv(key_iv),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int seed(input int x0, input int c);
    int r;
    int s;
    r = c % 16;
    s = ((x0 << r) | (x0 >> (16 - r))) & 32'hFFFF;
    return (s == 0) ? 1 : s;
  endfunction

  // x' = r*x*(1-x): x and 1-x as 16-bit fractions, r as a 2.14 gain
  function automatic int step(input int x, input int r);
    longint q;
    longint n;
    q = (longint'(x) * longint'(65535 - x)) >>> 16;
    n = ((longint'(r) * q) >>> 14) % 65536;
    return (n == 0) ? 1 : int'(n);
  endfunction

  task automatic model_reseed();
    for (int c = 0; c < CH; c++) begin
      mx[c]    = seed(kx0, c);
      mprev[c] = kiv;
    end
    mcnt = 0;
  endtask

  // one clock: drive inputs, check outputs at the falling edge, update model, advance past the rising edge
  task automatic cycle(input bit sv, input logic [23:0] d, input bit mr, input bit kl, input bit md);
    bit   exp_ready;
    bit   acc;
    int   k, p, o;
    logic [23:0] out;
    s_valid  = sv;
    s_data   = d;
    m_ready  = mr;
    key_load = kl;
    mode_r   = md;
    @(negedge clk);
    exp_ready = mkeyed && !kl && (!mv || mr);
    chk("s_ready", {31'b0, s_ready}, {31'b0, exp_ready});
    chk("m_valid", {31'b0, m_valid}, {31'b0, mv});
    if (mv) begin
      chk("m_data", {8'b0, m_data}, {8'b0, exp_data});
      chk("m_last", {31'b0, m_last}, {31'b0, exp_last});
    end
    acc = sv && exp_ready;
    if (acc) begin
      out = '0;
      for (int c = 0; c < CH; c++) begin
        k = mx[c] >> 8;
        p = int'(d[c*8 +: 8]);
        if (md) begin
          o = ((p ^ mprev[c]) - k) & 255;
          mprev[c] = p;
        end else begin
          o = ((p + k) & 255) ^ mprev[c];
          mprev[c] = o;
        end
        mx[c] = step(mx[c], kr);
        out[c*8 +: 8] = o[7:0];
      end
      exp_data = out;
      exp_last = (mcnt == NPIX - 1);
      mv = 1'b1;
      if (mcnt == NPIX - 1) model_reseed();
      else mcnt++;
    end else if (mr) begin
      mv = 1'b0;
    end
    if (kl) begin
      kx0 = int'(key_x0);
      kr  = int'(key_r);
      kiv = int'(key_iv);
      mkeyed = 1'b1;
      model_reseed();
    end
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode_r = 1'b0; key_load = 1'b0; key_x0 = '0; key_r = '0; key_iv = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    mkeyed = 1'b0; mv = 1'b0; mcnt = 0; kx0 = 0; kr = 0; kiv = 0;
    exp_data = '0; exp_last = 1'b0;
    for (int c = 0; c < CH; c++) begin mx[c] = 0; mprev[c] = 0; end

    // reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_data", {8'b0, m_data}, 32'd0);
    chk("rst_m_last", {31'b0, m_last}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 24'($urandom), 1'b1, 1'b0, 1'b0);

    // degenerate key: keystream is all zeros, output is pure feedback
    key_x0 = 16'h0000; key_r = 16'h0000; key_iv = 8'h00;
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 24'h121212, 1'b1, 1'b0, 1'b0);
    chk("degen_0", {8'b0, m_data}, 32'h00121212);
    cycle(1'b1, 24'h343434, 1'b1, 1'b0, 1'b0);
    chk("degen_1", {8'b0, m_data}, 32'h00262626);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // backpressure: five stalled cycles, then resume
    key_x0 = 16'($urandom); key_r = 16'($urandom_range(16'hE000, 16'hFFFF)); key_iv = 8'($urandom);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 24'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 24'($urandom), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // frame wrap: two identical frames give identical ciphertext
    for (int i = 0; i < NPIX; i++) frame_px[i] = 24'($urandom);
    key_x0 = 16'h5A5A; key_r = 16'($urandom_range(16'hC000, 16'hFFFF)); key_iv = 8'($urandom);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      cycle(1'b1, frame_px[i], 1'b1, 1'b0, 1'b0);
      ref_out[i] = exp_data;
      chk("f1_last", {31'b0, m_last}, {31'b0, (i == NPIX - 1)});
    end
    for (int i = 0; i < NPIX; i++) begin
      cycle(1'b1, frame_px[i], 1'b1, 1'b0, 1'b0);
      chk("f2_equal", {8'b0, m_data}, {8'b0, ref_out[i]});
      chk("f2_last", {31'b0, m_last}, {31'b0, (i == NPIX - 1)});
    end

    // key reload after three pixels restarts the frame
    for (int i = 0; i < 3; i++) cycle(1'b1, 24'($urandom), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 24'($urandom), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      cycle(1'b1, frame_px[i], 1'b1, 1'b0, 1'b0);
      chk("reload_equal", {8'b0, m_data}, {8'b0, ref_out[i]});
      chk("reload_last", {31'b0, m_last}, {31'b0, (i == NPIX - 1)});
    end

    // random traffic with random stalls and occasional rekeying
    key_x0 = 16'($urandom); key_r = 16'($urandom); key_iv = 8'($urandom);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        key_x0 = 16'($urandom); key_r = 16'($urandom); key_iv = 8'($urandom);
      end
      cycle(1'($urandom_range(0, 3) != 0), 24'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 39) == 0), 1'b0);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef CHAOS_DECRYPT_EN
    // round trip: encrypt 64 pixels, decrypt the model ciphertext, recover plaintext
    key_x0 = 16'h5A5A; key_r = 16'hF000; key_iv = 8'hA5;
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      plain[i] = 24'($urandom);
      cycle(1'b1, plain[i], 1'b1, 1'b0, 1'b0);
      ciph[i] = exp_data;
    end
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, ciph[i], 1'b1, 1'b0, 1'b1);
      chk("decrypt", {8'b0, m_data}, {8'b0, plain[i]});
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
